// File: rtl/async_fifo_pkg.sv
// Gray/binary pointer helpers shared by the dual-clock FIFO.
// Both work at any width up to GW bits: callers zero-extend in and truncate out.
package async_fifo_pkg;

    localparam int GW = 32;

    function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Leading zeros of a zero-extended Gray code decode to leading zeros, so one
    // full-width routine serves every pointer width.
    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b[GW-1] = g[GW-1];
        for (int i = GW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync2.sv
// Two-flop synchronizer for a Gray-coded pointer entering a new clock domain.
module fifo_sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/async_fifo.sv
// Dual-clock FIFO: Gray pointers cross domains through fifo_sync2; flags are
// registered from each side's next pointer so they never lag their own domain.
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int AW     = 3,
    parameter int DW     = 8,
    parameter int AF_LVL = 1,
    parameter int AE_LVL = 1
) (
    input  logic          wr_clk,
    input  logic          wr_reset_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          full,
    output logic          afull,
    input  logic          rd_clk,
    input  logic          rd_reset_n,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic          aempty
);

    localparam int PW    = AW + 1;
    localparam int DEPTH = 2 ** AW;

    typedef logic [PW-1:0] ptr_t;

    // Full when the write pointer has lapped the read pointer once: Gray top two bits differ.
    localparam ptr_t FULL_MASK = ptr_t'(3) << (PW - 2);
    localparam ptr_t AF_CNT    = ptr_t'(DEPTH - AF_LVL);
    localparam ptr_t AE_CNT    = ptr_t'(AE_LVL);

    logic [DW-1:0] mem [DEPTH];

    ptr_t wbin, wgray, wbin_next, wgray_next, wq2_rgray, wq2_rbin, wcnt;
    ptr_t rbin, rgray, rbin_next, rgray_next, rq2_wgray, rq2_wbin, rcnt;
    logic wr_ok, rd_ok;

    // ---------------- write domain ----------------
    assign wr_ok      = wr_en & ~full;
    assign wbin_next  = wbin + ptr_t'(wr_ok);
    assign wgray_next = ptr_t'(bin2gray(GW'(wbin_next)));
    assign wq2_rbin   = ptr_t'(gray2bin(GW'(wq2_rgray)));
    assign wcnt       = wbin_next - wq2_rbin;

    always_ff @(posedge wr_clk or negedge wr_reset_n) begin
        if (!wr_reset_n) begin
            wbin  <= '0;
            wgray <= '0;
            full  <= 1'b0;
            afull <= 1'b0;
        end else begin
            wbin  <= wbin_next;
            wgray <= wgray_next;
            full  <= (wgray_next == (wq2_rgray ^ FULL_MASK));
            afull <= (wcnt >= AF_CNT);
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_ok) begin
            mem[wbin[AW-1:0]] <= wr_data;
        end
    end

    fifo_sync2 #(.W(PW)) u_sync_r2w (
        .clk   (wr_clk),
        .rst_n (wr_reset_n),
        .d     (rgray),
        .q     (wq2_rgray)
    );

    // ---------------- read domain ----------------
    assign rd_ok      = rd_en & ~empty;
    assign rbin_next  = rbin + ptr_t'(rd_ok);
    assign rgray_next = ptr_t'(bin2gray(GW'(rbin_next)));
    assign rq2_wbin   = ptr_t'(gray2bin(GW'(rq2_wgray)));
    assign rcnt       = rq2_wbin - rbin_next;

    always_ff @(posedge rd_clk or negedge rd_reset_n) begin
        if (!rd_reset_n) begin
            rbin    <= '0;
            rgray   <= '0;
            empty   <= 1'b1;
            aempty  <= 1'b1;
            rd_data <= '0;
        end else begin
            rbin   <= rbin_next;
            rgray  <= rgray_next;
            empty  <= (rgray_next == rq2_wgray);
            aempty <= (rcnt <= AE_CNT);
            if (rd_ok) begin
                rd_data <= mem[rbin[AW-1:0]];
            end
        end
    end

    fifo_sync2 #(.W(PW)) u_sync_w2r (
        .clk   (rd_clk),
        .rst_n (rd_reset_n),
        .d     (wgray),
        .q     (rq2_wgray)
    );

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo: fill table, drain, streaming, single word,
// read-on-empty and mid-stream reset.
module tb_async_fifo;

    localparam int AW = 3;
    localparam int DW = 8;

    logic          wr_clk = 1'b0;
    logic          rd_clk = 1'b0;
    logic          wr_reset_n = 1'b0;
    logic          rd_reset_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic          full, afull, empty, aempty;

    async_fifo #(.AW(AW), .DW(DW), .AF_LVL(1), .AE_LVL(1)) dut (
        .wr_clk     (wr_clk),
        .wr_reset_n (wr_reset_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .afull      (afull),
        .rd_clk     (rd_clk),
        .rd_reset_n (rd_reset_n),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .aempty     (aempty)
    );

    // wr posedges at 15+30k, rd posedges at 10+20k: they never coincide.
    always #15 wr_clk = ~wr_clk;
    always #10 rd_clk = ~rd_clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          wr_en;
        logic [DW-1:0] data;
        logic          exp_full;
        logic          exp_afull;
    } wvec_t;

    wvec_t wv [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wr_one(input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge wr_clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic rd_one(output logic [DW-1:0] d);
        int n;
        n = 0;
        while (empty && n < 10) begin
            @(posedge rd_clk);
            #1;
            n++;
        end
        chk("rd_wait_not_empty", 32'(empty), 32'd0);
        rd_en = 1'b1;
        @(posedge rd_clk);
        #1;
        rd_en = 1'b0;
        d = rd_data;
    endtask

    int       wcount = 0;
    int       rcount = 0;
    bit       prod_done = 1'b0;
    logic [DW-1:0] d;

    initial begin
        // fill table: reads held off, flags after each accepting edge
        wv[0] = '{1'b1, 8'd6,  1'b0, 1'b0};
        wv[1] = '{1'b1, 8'd7,  1'b0, 1'b0};
        wv[2] = '{1'b1, 8'd8,  1'b0, 1'b0};
        wv[3] = '{1'b1, 8'd9,  1'b0, 1'b0};
        wv[4] = '{1'b1, 8'd10, 1'b0, 1'b0};
        wv[5] = '{1'b1, 8'd11, 1'b0, 1'b0};
        wv[6] = '{1'b1, 8'd12, 1'b0, 1'b1};
        wv[7] = '{1'b1, 8'd13, 1'b1, 1'b1};
        wv[8] = '{1'b1, 8'd14, 1'b1, 1'b1};
        wv[9] = '{1'b1, 8'd15, 1'b1, 1'b1};

        // 1. reset
        repeat (10) @(posedge wr_clk);
        #1;
        chk("rst_full",    32'(full),    32'd0);
        chk("rst_afull",   32'(afull),   32'd0);
        chk("rst_empty",   32'(empty),   32'd1);
        chk("rst_aempty",  32'(aempty),  32'd1);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        wr_reset_n = 1'b1;
        rd_reset_n = 1'b1;
        @(posedge wr_clk);
        #1;

        // 2. fill past full, then drain
        for (int i = 0; i < 10; i++) begin
            wr_en   = wv[i].wr_en;
            wr_data = wv[i].data;
            @(posedge wr_clk);
            #1;
            chk($sformatf("fill_full[%0d]", i),  32'(full),  32'(wv[i].exp_full));
            chk($sformatf("fill_afull[%0d]", i), 32'(afull), 32'(wv[i].exp_afull));
        end
        wr_en = 1'b0;
        repeat (5) @(posedge rd_clk);
        #1;
        chk("fill_empty",  32'(empty),  32'd0);
        chk("fill_aempty", 32'(aempty), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd_one(d);
            chk($sformatf("drain_data[%0d]", i), 32'(d), 32'(6 + i));
            chk($sformatf("drain_aempty[%0d]", i), 32'(aempty), 32'((7 - i) <= 1));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        repeat (4) @(posedge wr_clk);
        #1;
        chk("drain_full",  32'(full),  32'd0);
        chk("drain_afull", 32'(afull), 32'd0);

        // 3. streaming across pointer and byte wrap
        fork
            begin
                logic [DW-1:0] wd;
                wd = 8'd6;
                for (int c = 0; c < 1024; c++) begin
                    wr_en   = ~full;
                    wr_data = wd;
                    @(posedge wr_clk);
                    #1;
                    if (wr_en) begin
                        wd++;
                        wcount++;
                    end
                end
                wr_en = 1'b0;
                prod_done = 1'b1;
            end
            begin
                logic [DW-1:0] ed;
                int idle;
                int iter;
                ed = 8'd6;
                idle = 0;
                iter = 0;
                while (!(prod_done && rcount == wcount) && idle < 200 && iter < 4000) begin
                    rd_en = ~empty;
                    @(posedge rd_clk);
                    #1;
                    iter++;
                    if (rd_en) begin
                        chk($sformatf("stream[%0d]", rcount), 32'(rd_data), 32'(ed));
                        ed++;
                        rcount++;
                        idle = 0;
                    end else begin
                        idle++;
                    end
                end
                rd_en = 1'b0;
            end
        join
        chk("stream_count", 32'(rcount), 32'(wcount));
        chk("stream_wrapped", 32'(wcount > 300), 32'd1);
        chk("stream_empty", 32'(empty), 32'd1);

        // 4. single word latency
        wr_one(8'hA5);
        begin
            int n;
            n = 0;
            while (empty && n < 3) begin
                @(posedge rd_clk);
                #1;
                n++;
            end
        end
        chk("a5_empty_fall", 32'(empty), 32'd0);
        rd_one(d);
        chk("a5_data",  32'(d),     32'hA5);
        chk("a5_empty", 32'(empty), 32'd1);

        // 5. read while empty is ignored
        rd_en = 1'b1;
        repeat (5) @(posedge rd_clk);
        #1;
        chk("rdempty_hold", 32'(rd_data), 32'hA5);
        chk("rdempty_empty", 32'(empty), 32'd1);
        rd_en = 1'b0;
        wr_one(8'h3C);
        rd_one(d);
        chk("rdempty_next", 32'(d), 32'h3C);
        chk("rdempty_after", 32'(empty), 32'd1);

        // 6. reset with 5 words stored
        for (int i = 0; i < 5; i++) wr_one(8'(8'h50 + i));
        repeat (5) @(posedge rd_clk);
        #1;
        chk("pre_rst_aempty", 32'(aempty), 32'd0);
        #7;
        wr_reset_n = 1'b0;
        rd_reset_n = 1'b0;
        #1;
        chk("midrst_empty",   32'(empty),   32'd1);
        chk("midrst_full",    32'(full),    32'd0);
        chk("midrst_aempty",  32'(aempty),  32'd1);
        chk("midrst_rd_data", 32'(rd_data), 32'd0);
        repeat (3) @(posedge wr_clk);
        #4;
        wr_reset_n = 1'b1;
        rd_reset_n = 1'b1;
        @(posedge wr_clk);
        #1;
        for (int i = 0; i < 3; i++) wr_one(8'(8'h10 + i));
        for (int i = 0; i < 3; i++) begin
            rd_one(d);
            chk($sformatf("postrst_data[%0d]", i), 32'(d), 32'(8'h10 + i));
        end
        chk("postrst_empty", 32'(empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
